// File: rtl/cpu_gen.sv
// cpu_gen: parametrised accumulator CPU, multicycle FSM, single-port memory.
// Define CPU_GEN_INTR_EN to build the IEN/R flags and the INTR cycle.
module cpu_gen #(
  parameter int          DATA_W = 16,
  parameter int          ADDR_W = 12,
  parameter int unsigned RST_PC = 0
) (
  input  logic              clkin,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              en,
  output logic              rdwr,
  input  logic              en_inp,
  input  logic              en_out,
  input  logic [7:0]        keyboard,
  output logic [7:0]        display,
  output logic              halted
);

  typedef enum logic [3:0] {
    FETCH, FETCH_W, DECODE, IND_W,
    EXEC1, EXEC2, EXEC3, INTR, HALT
  } state_t;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_pc, r_ar;
  logic [DATA_W-1:0] r_ac, r_dr, r_ir;
  logic              r_e;
  logic [7:0]        r_display;

  logic              w_i, w_rref, w_io, w_irq;
  logic [2:0]        w_op;
  logic [ADDR_W-1:0] w_fld;
  logic [11:0]       w_rr;
  logic [DATA_W-1:0] w_pc_ext;
  logic [DATA_W:0]   w_sum;

  logic              w_en, w_rdwr, w_end;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_dout;

  logic [DATA_W-1:0] w_t, w_ac_rr;
  logic              w_te, w_e_rr;
  logic              w_skip_rr, w_skip_io;

  assign w_i      = r_ir[DATA_W-1];
  assign w_op     = r_ir[DATA_W-2:DATA_W-4];
  assign w_fld    = r_ir[ADDR_W-1:0];
  assign w_rr     = r_ir[11:0];
  assign w_rref   = (w_op == 3'd7) && !w_i;
  assign w_io     = (w_op == 3'd7) && w_i;
  assign w_pc_ext = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
  assign w_sum    = {1'b0, r_ac} + {1'b0, datain};

  // AC chain: CLA, CMA, INC, then rotate through the updated E
  always_comb begin
    w_t = w_rr[11] ? '0 : r_ac;
    if (w_rr[9]) w_t = ~w_t;
    if (w_rr[5]) w_t = w_t + 1'b1;
    w_te = w_rr[10] ? 1'b0 : r_e;
    if (w_rr[8]) w_te = ~w_te;
    w_ac_rr = w_t;
    w_e_rr  = w_te;
    if (w_rr[7]) begin
      w_ac_rr = {w_te, w_t[DATA_W-1:1]};
      w_e_rr  = w_t[0];
    end else if (w_rr[6]) begin
      w_ac_rr = {w_t[DATA_W-2:0], w_te};
      w_e_rr  = w_t[DATA_W-1];
    end
  end

  assign w_skip_rr = (w_rr[4] & ~r_ac[DATA_W-1])
                   | (w_rr[3] &  r_ac[DATA_W-1])
                   | (w_rr[2] & (r_ac == '0))
                   | (w_rr[1] & ~r_e);
  assign w_skip_io = (w_rr[9] & en_inp) | (w_rr[8] & en_out);

  always_ff @(posedge clkin) begin
    if (!rst) r_state <= FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_en   = 1'b0;
    w_rdwr = 1'b0;
    w_addr = r_pc;
    w_dout = '0;
    w_end  = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_en   = 1'b1;
        w_next = FETCH_W;
      end
      FETCH_W: w_next = DECODE;
      DECODE: begin
        if (w_op != 3'd7 && w_i) begin
          w_en   = 1'b1;
          w_addr = w_fld;
          w_next = IND_W;
        end else begin
          w_next = EXEC1;
        end
      end
      IND_W: w_next = EXEC1;
      EXEC1: begin
        case (w_op)
          3'd0, 3'd1, 3'd2, 3'd6: begin
            w_en   = 1'b1;
            w_addr = r_ar;
            w_next = EXEC2;
          end
          3'd3: begin
            w_en   = 1'b1;
            w_rdwr = 1'b1;
            w_addr = r_ar;
            w_dout = r_ac;
            w_end  = 1'b1;
          end
          3'd5: begin
            w_en   = 1'b1;
            w_rdwr = 1'b1;
            w_addr = r_ar;
            w_dout = w_pc_ext;
            w_end  = 1'b1;
          end
          3'd7: begin
            if (w_rref && w_rr[0]) w_next = HALT;
            else                   w_end  = 1'b1;
          end
          default: w_end = 1'b1;
        endcase
      end
      EXEC2: begin
        if (w_op == 3'd6) w_next = EXEC3;
        else              w_end  = 1'b1;
      end
      EXEC3: begin
        w_en   = 1'b1;
        w_rdwr = 1'b1;
        w_addr = r_ar;
        w_dout = r_dr;
        w_end  = 1'b1;
      end
`ifdef CPU_GEN_INTR_EN
      INTR: begin
        w_en   = 1'b1;
        w_rdwr = 1'b1;
        w_addr = '0;
        w_dout = w_pc_ext;
        w_next = FETCH;
      end
`endif
      HALT: w_next = HALT;
      default: w_next = FETCH;
    endcase
    if (w_end) w_next = w_irq ? INTR : FETCH;
  end

  always_ff @(posedge clkin) begin
    if (!rst) begin
      r_pc      <= ADDR_W'(RST_PC);
      r_ar      <= '0;
      r_ac      <= '0;
      r_dr      <= '0;
      r_ir      <= '0;
      r_e       <= 1'b0;
      r_display <= '0;
    end else begin
      case (r_state)
        FETCH_W: begin
          r_ir <= datain;
          r_pc <= r_pc + 1'b1;
        end
        DECODE: r_ar <= w_fld;
        IND_W:  r_ar <= datain[ADDR_W-1:0];
        EXEC1: begin
          if (w_rref) begin
            r_ac <= w_ac_rr;
            r_e  <= w_e_rr;
            if (w_skip_rr) r_pc <= r_pc + 1'b1;
          end else if (w_io) begin
            if (w_rr[11] && en_inp) r_ac[7:0] <= keyboard;
            if (w_rr[10] && en_out) r_display <= r_ac[7:0];
            if (w_skip_io) r_pc <= r_pc + 1'b1;
          end else if (w_op == 3'd4) begin
            r_pc <= r_ar;
          end else if (w_op == 3'd5) begin
            r_pc <= r_ar + 1'b1;
          end
        end
        EXEC2: begin
          r_dr <= (w_op == 3'd6) ? datain + 1'b1 : datain;
          case (w_op)
            3'd0:    r_ac <= r_ac & datain;
            3'd1:    {r_e, r_ac} <= w_sum;
            3'd2:    r_ac <= datain;
            default: ;
          endcase
        end
        EXEC3: if (r_dr == '0) r_pc <= r_pc + 1'b1;
`ifdef CPU_GEN_INTR_EN
        INTR: r_pc <= ADDR_W'(1);
`endif
        default: ;
      endcase
    end
  end

`ifdef CPU_GEN_INTR_EN
  logic r_ien, r_r;

  always_ff @(posedge clkin) begin
    if (!rst) begin
      r_ien <= 1'b0;
      r_r   <= 1'b0;
    end else if (r_state == INTR) begin
      r_ien <= 1'b0;
      r_r   <= 1'b0;
    end else begin
      if (r_state == EXEC1 && w_io) begin
        if (w_rr[7]) r_ien <= 1'b1;
        if (w_rr[6]) r_ien <= 1'b0;
      end
      if (r_ien && (en_inp | en_out) && r_state != HALT)
        r_r <= 1'b1;
    end
  end

  assign w_irq = r_r;
`else
  assign w_irq = 1'b0;
`endif

  // no bus activity is ever presented while reset is held
  assign addr    = w_addr;
  assign en      = w_en & rst;
  assign rdwr    = w_rdwr & rst;
  assign dataout = rst ? w_dout : '0;
  assign display = r_display;
  assign halted  = (r_state == HALT);

endmodule

// File: tb/tb_cpu_gen.sv
// tb_cpu_gen: directed programs, expected memory writes checked by a
// scoreboard monitor; bus reads logged for address-sequence checks.
module tb_cpu_gen;

  logic        clkin = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] addr;
  logic [15:0] datain = '0;
  logic [15:0] dataout;
  logic        en, rdwr;
  logic        en_inp = 1'b0;
  logic        en_out = 1'b0;
  logic [7:0]  keyboard = '0;
  logic [7:0]  display;
  logic        halted;

  cpu_gen #(.DATA_W(16), .ADDR_W(12), .RST_PC(0)) dut (
    .clkin(clkin), .rst(rst), .addr(addr), .datain(datain),
    .dataout(dataout), .en(en), .rdwr(rdwr), .en_inp(en_inp),
    .en_out(en_out), .keyboard(keyboard), .display(display),
    .halted(halted)
  );

  always #5 clkin = ~clkin;

  logic [15:0] mem [0:4095];

  always @(posedge clkin) begin
    if (en) begin
      if (rdwr) mem[addr] = dataout;
      else      datain <= mem[addr];
    end
  end

  typedef struct packed {
    logic [11:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [11:0] rd_log[$];
  wr_t         mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(negedge clkin) begin
    if (rst && en) begin
      if (!rdwr) begin
        rd_log.push_back(addr);
      end else begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got %h<=%h, required none",
                   addr, dataout);
        end else begin
          mon_e = exp_q.pop_front();
          if (addr !== mon_e.a || dataout !== mon_e.d) begin
            n_bad++;
            $display("FAIL write: got %h<=%h, required %h<=%h",
                     addr, dataout, mon_e.a, mon_e.d);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  task automatic expw(input logic [11:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b0;
    repeat (2) @(posedge clkin);
    #1;
    rd_log.delete();
    check({nm, "_rst_bus"}, {en, rdwr, dataout}, 32'h0);
    check({nm, "_rst_io"}, {halted, display}, 32'h0);
    rst = 1'b1;
    #1;
    check({nm, "_first_fetch"}, {en, rdwr, addr}, {18'h0, 2'b10, 12'h000});
  endtask

  task automatic run_halt(input string nm, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clkin);
      #1;
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
    check({nm, "_halted"}, {31'h0, halted}, 32'h1);
    repeat (2) @(posedge clkin);
    #1;
    check({nm, "_pending_writes"}, exp_q.size(), 32'h0);
    if (!ok) exp_q.delete();
  endtask

  initial begin
    int  c;
    bit  found;

    // LDA / ADD with carry / STA, then PC via BSA, E via CLA+CIL
    clr_mem();
    mem[12'h000] = 16'h2010; mem[12'h001] = 16'h1011;
    mem[12'h002] = 16'h3012; mem[12'h003] = 16'h5040;
    mem[12'h010] = 16'h1234; mem[12'h011] = 16'hF000;
    mem[12'h041] = 16'h7840; mem[12'h042] = 16'h3013;
    mem[12'h043] = 16'h7001;
    expw(12'h012, 16'h0234);
    expw(12'h040, 16'h0004);
    expw(12'h013, 16'h0001);
    do_reset("add");
    run_halt("add", 200);

    // indirect BUN through M[0x020]
    clr_mem();
    mem[12'h000] = 16'hC020; mem[12'h020] = 16'h0100;
    mem[12'h100] = 16'h5050; mem[12'h051] = 16'h7001;
    expw(12'h050, 16'h0101);
    do_reset("bun");
    run_halt("bun", 200);
    check("bun_rd0", (rd_log.size() > 0) ? rd_log[0] : 12'hFFF, 12'h000);
    check("bun_rd1", (rd_log.size() > 1) ? rd_log[1] : 12'hFFF, 12'h020);
    check("bun_rd2", (rd_log.size() > 2) ? rd_log[2] : 12'hFFF, 12'h100);

    // ISZ wrapping to zero skips the next word
    clr_mem();
    mem[12'h000] = 16'h6030; mem[12'h001] = 16'h7001;
    mem[12'h002] = 16'h5060; mem[12'h030] = 16'hFFFF;
    mem[12'h061] = 16'h7001;
    expw(12'h030, 16'h0000);
    expw(12'h060, 16'h0003);
    do_reset("isz0");
    run_halt("isz0", 200);

    // ISZ non-zero, no skip; then AND
    clr_mem();
    mem[12'h000] = 16'h6031; mem[12'h001] = 16'h5060;
    mem[12'h031] = 16'h0005; mem[12'h061] = 16'h2031;
    mem[12'h062] = 16'h0070; mem[12'h063] = 16'h3071;
    mem[12'h064] = 16'h7001; mem[12'h070] = 16'h0003;
    expw(12'h031, 16'h0006);
    expw(12'h060, 16'h0002);
    expw(12'h071, 16'h0002);
    do_reset("isz1");
    run_halt("isz1", 200);

    // CLA+CMA+CIL, SZA no skip, E via CIL, HLT holds the bus idle
    clr_mem();
    mem[12'h000] = 16'h7A40; mem[12'h001] = 16'h3020;
    mem[12'h002] = 16'h7004; mem[12'h003] = 16'h5070;
    mem[12'h071] = 16'h7840; mem[12'h072] = 16'h3021;
    mem[12'h073] = 16'h7001;
    expw(12'h020, 16'hFFFE);
    expw(12'h070, 16'h0004);
    expw(12'h021, 16'h0001);
    do_reset("rref");
    run_halt("rref", 200);
    c = 0;
    repeat (20) begin
      @(negedge clkin);
      if (en) c++;
    end
    check("halt_no_access", c, 0);
    check("halt_hold", {31'h0, halted}, 32'h1);

    // INC, CIR, SZA skip, SZE no skip, CMA+CME, SNA skip
    clr_mem();
    mem[12'h000] = 16'h7020; mem[12'h001] = 16'h7080;
    mem[12'h002] = 16'h7004; mem[12'h003] = 16'h7001;
    mem[12'h004] = 16'h7002; mem[12'h005] = 16'h5070;
    mem[12'h071] = 16'h7300; mem[12'h072] = 16'h7008;
    mem[12'h073] = 16'h7001; mem[12'h074] = 16'h3022;
    mem[12'h075] = 16'h7001;
    expw(12'h070, 16'h0006);
    expw(12'h022, 16'hFFFF);
    do_reset("skip");
    run_halt("skip", 300);

    // I/O: INP keeps upper AC bits, OUT, SKI
    clr_mem();
    en_inp = 1'b1; en_out = 1'b1; keyboard = 8'hA5;
    mem[12'h000] = 16'h2010; mem[12'h001] = 16'hF800;
    mem[12'h002] = 16'hF400; mem[12'h003] = 16'h3011;
    mem[12'h004] = 16'hF200; mem[12'h005] = 16'h7001;
    mem[12'h006] = 16'h5070; mem[12'h010] = 16'h1200;
    mem[12'h071] = 16'h7001;
    expw(12'h011, 16'h12A5);
    expw(12'h070, 16'h0007);
    do_reset("io");
    run_halt("io", 300);
    check("io_display", display, 8'hA5);
    en_inp = 1'b0; en_out = 1'b0;

    // ION, NOP with a pending input flag
    clr_mem();
    en_inp = 1'b1;
    mem[12'h000] = 16'hF080; mem[12'h001] = 16'h7000;
    mem[12'h002] = 16'h5070; mem[12'h071] = 16'h7001;
`ifdef CPU_GEN_INTR_EN
    expw(12'h000, 16'h0002);
`endif
    expw(12'h070, 16'h0003);
    do_reset("intr");
    run_halt("intr", 300);
`ifdef CPU_GEN_INTR_EN
    check("intr_ret_pc", mem[12'h000], 16'h0002);
`else
    check("intr_none", mem[12'h000], 16'hF080);
`endif
    en_inp = 1'b0;

    // reset asserted during the ISZ write cycle
    clr_mem();
    mem[12'h000] = 16'h6030; mem[12'h001] = 16'h7001;
    mem[12'h030] = 16'h0041;
    expw(12'h030, 16'h0042);
    do_reset("abort");
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clkin);
      #1;
      if (en && rdwr) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_write_seen", {31'h0, found}, 32'h1);
    rst = 1'b0;
    @(posedge clkin);
    #1;
    check("abort_en", {31'h0, en}, 32'h0);
    check("abort_mem", mem[12'h030], 16'h0041);
    rst = 1'b1;
    #1;
    check("abort_refetch", {en, rdwr, addr}, {18'h0, 2'b10, 12'h000});
    expw(12'h030, 16'h0042);
    run_halt("abort", 200);
    check("abort_rerun_mem", mem[12'h030], 16'h0042);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
